// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences fetch/decode/execute/
// memory/write-back and decodes Moore control outputs from the current state.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_en,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_ct_op,
    output logic       insn_done,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // 4-bit plain register so the unused encodings 12-15 are representable and recover.
    logic [3:0] state_q, state_d;

    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_FETCH;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDIU:     state_d = S_ADDIEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_LW)      state_d = S_MEMRD;
                else if (opcode == OP_SW) state_d = S_MEMWR;
                else                      state_d = S_FETCH;
            end
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Outputs are gated by rst so an asserted reset silences the datapath in the same cycle.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_ct_op     = 2'b00;
        insn_done     = 1'b0;
        illegal       = 1'b0;
        state         = 4'd0;
        if (rst) begin
            state = state_q;
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = 2'b01;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    case (opcode)
                        OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDIU: illegal = 1'b0;
                        default: illegal = 1'b1;
                    endcase
                    insn_done = illegal;
                end
                S_MEMADR, S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    i_or_d   = 1'b1;
                    mem_read = 1'b1;
                end
                S_MEMWR: begin
                    i_or_d    = 1'b1;
                    mem_write = 1'b1;
                    insn_done = 1'b1;
                end
                S_MEMWB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                    insn_done  = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_ct_op = 2'b10;
                end
                S_ALUWB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                    insn_done = 1'b1;
                end
                S_ADDIWB: begin
                    reg_write = 1'b1;
                    insn_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_ct_op     = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    insn_done     = 1'b1;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                    insn_done = 1'b1;
                end
                default: state = state_q;
            endcase
        end
    end

    assign pc_en = pc_write | (pc_write_cond & zero);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized scoreboard bench for multicycle_ctrl: per-instruction state paths are
// expanded into expected per-cycle output vectors and checked by an independent monitor.
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       pc_write, pc_write_cond, pc_en;
    logic [1:0] pc_source;
    logic       i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_ct_op;
    logic       insn_done, illegal;
    logic [3:0] state;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_en(pc_en),
        .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ct_op(alu_ct_op), .insn_done(insn_done),
        .illegal(illegal), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_ADDIU = 6'b001001, OP_LW = 6'b100011, OP_SW = 6'b101011;

    int errors = 0;
    int checks = 0;
    logic [22:0] exp_q[$];
    int seq[$];

    function automatic logic [22:0] pack(
        logic pw, logic pwc, logic pen, logic [1:0] psrc, logic iord, logic mr, logic mw,
        logic irw, logic rd, logic m2r, logic rw, logic asa, logic [1:0] asb,
        logic [1:0] aop, logic done, logic ill, logic [3:0] st);
        return {pw, pwc, pen, psrc, iord, mr, mw, irw, rd, m2r, rw, asa, asb, aop, done, ill, st};
    endfunction

    // Path of states each instruction class walks through, FETCH first.
    function automatic void build_seq(logic [5:0] op);
        seq.delete();
        case (op)
            OP_LW:    seq = '{0, 1, 2, 3, 4};
            OP_SW:    seq = '{0, 1, 2, 5};
            OP_R:     seq = '{0, 1, 6, 7};
            OP_ADDIU: seq = '{0, 1, 10, 11};
            OP_BEQ:   seq = '{0, 1, 8};
            OP_J:     seq = '{0, 1, 9};
            default:  seq = '{0, 1};
        endcase
    endfunction

    // Control table by state; completion is simply "last step of the path".
    function automatic logic [22:0] exp_out(int st, logic z, bit last);
        logic pw = 0, pwc = 0, iord = 0, mr = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, asa = 0;
        logic [1:0] psrc = 0, asb = 0, aop = 0;
        case (st)
            0:  begin mr = 1; irw = 1; pw = 1; asb = 2'b01; end
            1:  asb = 2'b11;
            2, 10: begin asa = 1; asb = 2'b10; end
            3:  begin iord = 1; mr = 1; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin iord = 1; mw = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rd = 1; rw = 1; end
            8:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
            9:  begin pw = 1; psrc = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return pack(pw, pwc, pw | (pwc & z), psrc, iord, mr, mw, irw, rd, m2r, rw, asa, asb,
                    aop, last, (st == 1) && last, 4'(st));
    endfunction

    task automatic reset_cycles(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rst = 1'b0;
            opcode = 6'($urandom);
            zero = 1'($urandom);
            exp_q.push_back(23'd0);
        end
    endtask

    // zmode: 0 random, 1 force zero=1, 2 force zero=0. abort_at<0 runs to completion.
    task automatic run_insn(logic [5:0] op, int zmode, int abort_at, int rst_n);
        build_seq(op);
        for (int i = 0; i < seq.size(); i++) begin
            if (i == abort_at) break;
            @(posedge clk); #1;
            rst = 1'b1;
            opcode = op;
            zero = (zmode == 1) ? 1'b1 : (zmode == 2) ? 1'b0 : 1'($urandom);
            exp_q.push_back(exp_out(seq[i], zero, i == seq.size() - 1));
        end
        if (abort_at >= 0) reset_cycles(rst_n);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [22:0] e, g;
            e = exp_q.pop_front();
            g = pack(pc_write, pc_write_cond, pc_en, pc_source, i_or_d, mem_read, mem_write,
                     ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_ct_op,
                     insn_done, illegal, state);
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL outputs t=%0t state got=%0d exp=%0d vec got=%h exp=%h",
                         $time, g[3:0], e[3:0], g, e);
            end
        end
    end

    initial begin
        logic [5:0] ops[6];
        ops = '{OP_LW, OP_SW, OP_R, OP_ADDIU, OP_BEQ, OP_J};
        rst = 1'b0;
        opcode = 6'd0;
        zero = 1'b0;
        reset_cycles(2);
        // Reset from the middle of an lw, held 3 cycles.
        run_insn(OP_LW, 0, 3, 3);
        run_insn(OP_LW, 0, -1, 0);
        run_insn(OP_SW, 0, -1, 0);
        run_insn(OP_R, 0, -1, 0);
        run_insn(OP_ADDIU, 0, -1, 0);
        run_insn(OP_BEQ, 1, -1, 0);
        run_insn(OP_BEQ, 2, -1, 0);
        run_insn(OP_J, 0, -1, 0);
        run_insn(6'b111111, 0, -1, 0);
        // Reset lands on the cycle that would have been MEMWR.
        run_insn(OP_SW, 0, 3, 1);
        run_insn(OP_R, 0, -1, 0);
        for (int n = 0; n < 300; n++) begin
            logic [5:0] op;
            int sel;
            sel = int'($urandom_range(0, 7));
            op = (sel < 6) ? ops[sel] : 6'($urandom);
            if ($urandom_range(0, 9) == 0)
                run_insn(op, 0, int'($urandom_range(0, 4)), int'($urandom_range(1, 3)));
            else
                run_insn(op, 0, -1, 0);
        end
        @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending got=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control state machine for the multi-cycle MIPS datapath. It sequences fetch, decode, execute, memory and write-back over several cycles per instruction. It drives the `alu_ct_op` code consumed by the ALU control decoder, along with all mux selects, register/memory enables and PC update controls. It sits between the instruction register's opcode field and the datapath.

## Interface

Parameters: none (fixed encodings below).

- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-low
- opcode  input  6  IR[31:26], valid from DECODE onward
- zero  input  1  ALU zero flag, combinational from ALU
- pc_write  output  1  unconditional PC write
- pc_write_cond  output  1  PC write if zero (beq)
- pc_en  output  1  pc_write | (pc_write_cond & zero)
- pc_source  output  2  00 ALU result, 01 ALUOut register, 10 jump target
- i_or_d  output  1  memory address: 0 PC, 1 ALUOut
- mem_read  output  1  memory read enable
- mem_write  output  1  memory write enable
- ir_write  output  1  instruction register load
- reg_dst  output  1  write register: 0 rt, 1 rd
- mem_to_reg  output  1  write data: 0 ALUOut, 1 MDR
- reg_write  output  1  register file write enable
- alu_src_a  output  1  ALU A: 0 PC, 1 register A
- alu_src_b  output  2  ALU B: 00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_ct_op  output  2  to ALU control: 00 add, 01 subtract, 10 use funct
- insn_done  output  1  high in the final cycle of each instruction
- illegal  output  1  high in DECODE when opcode unsupported
- state  output  4  current state, for debug

## Operation

- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11.
- Supported opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, j 000010, addiu 001001.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEMADR (lw/sw), EXEC (R), BRANCH (beq), JUMP (j), ADDIEX (addiu); any other opcode →FETCH with illegal=1.
  - MEMADR→MEMRD (lw) or MEMWR (sw). The opcode held in IR is sampled again here.
  - MEMRD→MEMWB; EXEC→ALUWB; ADDIEX→ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP→FETCH.
  - States 12–15→FETCH, all outputs 0.
- Moore outputs, decoded combinationally from the state register. Unlisted outputs are 0 in each state:
  - FETCH: mem_read, ir_write, pc_write=1; alu_src_b=01; alu_ct_op=00; pc_source=00.
  - DECODE: alu_src_b=11; alu_ct_op=00 (branch target into ALUOut).
  - MEMADR, ADDIEX: alu_src_a=1; alu_src_b=10; alu_ct_op=00.
  - MEMRD: i_or_d=1, mem_read=1.
  - MEMWR: i_or_d=1, mem_write=1.
  - MEMWB: mem_to_reg=1, reg_write=1, reg_dst=0.
  - EXEC: alu_src_a=1; alu_src_b=00; alu_ct_op=10.
  - ALUWB: reg_dst=1, reg_write=1.
  - ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0.
  - BRANCH: alu_src_a=1; alu_src_b=00; alu_ct_op=01; pc_write_cond=1; pc_source=01.
  - JUMP: pc_write=1; pc_source=10.
- insn_done=1 in MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP, plus DECODE when illegal.
- pc_en is the only output that also depends on an input (zero).

## Timing

- Reset: while rst=0, all outputs are forced to 0 combinationally, state output included. A clock edge with rst=0 loads FETCH.
- The first cycle after rst returns to 1 is FETCH.
- Reset mid-instruction aborts it. No partial write occurs after the reset edge.
- Cycles per instruction, counted FETCH to final state inclusive:
  - lw: 5
  - sw, R-type, addiu: 4
  - beq, j: 3
  - illegal: 2
- One state per clock; no stall input. Memory is assumed single-cycle.
- pc_en follows zero combinationally within the BRANCH cycle.
- mem_read and mem_write are never high in the same cycle.
- reg_write and mem_write are never high in the same cycle.

## Test plan

- Reset: hold rst=0 for 3 cycles from an arbitrary state → all outputs 0. Release → state=0, mem_read=1, ir_write=1, pc_en=1.
- lw (opcode 100011): state sequence 0,1,2,3,4,0. MEMRD has i_or_d=1. MEMWB has reg_write=1, mem_to_reg=1. insn_done pulses in cycle 5 only.
- sw, then R-type 000000, then addiu 001001:
  - sw: sequence 0,1,2,5,0 with mem_write=1 in state 5.
  - R-type: EXEC has alu_ct_op=10; ALUWB has reg_dst=1.
  - addiu: ADDIEX has alu_src_b=10; ADDIWB has reg_dst=0.
- beq (000100): with zero=1, BRANCH has pc_en=1 and pc_source=01. With zero=0, pc_en=0. Both cases return to FETCH after 3 cycles.
- j (000010) → JUMP has pc_write=1 and pc_source=10. Opcode 111111 → DECODE has illegal=1 and insn_done=1; next state is 0.
- Reset asserted during MEMWR → next cycle state=0. No mem_write after the reset edge.
